branch_predict_ctrl: RTL and testbench

//   Dynamic branch predictor and mispredict-recovery sequencer for the RISC-V core.

---
 rtl/core_pkg.sv | 17 +
 rtl/bp_sat_ctr2.sv | 28 ++
 rtl/branch_predict_ctrl.sv | 163 ++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// sequencer states and the conditional-branch opcode.
package core_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Next-value logic for one 2-bit saturating branch counter.
module bp_sat_ctr2
    import core_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] next
);

    // Step toward the observed outcome, holding at the ends of the range
    always_comb begin
        next = ctr;
        if (taken) begin
            if (ctr == ST) begin
                next = ST;
            end else begin
                next = ctr + 2'd1;
            end
        end else begin
            if (ctr == SNT) begin
                next = SNT;
            end else begin
                next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// PC-indexed 2-bit counter predictor with mispredict redirect, fixed-length
// IF/ID flush sequencer and saturating branch/mispredict statistics.
module branch_predict_ctrl
    import core_pkg::*;
#(
    parameter int         PC_W         = 32,
    parameter int         IDX_BITS     = 6,
    parameter logic [1:0] INIT_CTR     = 2'b01,
    parameter int         FLUSH_CYCLES = 2,
    parameter int         STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush_o,
    input  logic              cnt_clr,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int                ENTRIES  = 2 ** IDX_BITS;
    localparam int                FCNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_TOP = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
    localparam logic [PC_W-1:0]   PC_STEP  = PC_W'(4);

    logic [1:0]          ctr_q [ENTRIES];
    bp_state_e           state_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                redirect_valid_q;
    logic [PC_W-1:0]     redirect_pc_q;
    logic                flush_q;
    logic [STAT_W-1:0]   branch_cnt_q;
    logic [STAT_W-1:0]   mispred_cnt_q;
    logic [STAT_W-1:0]   branch_cnt_d;
    logic [STAT_W-1:0]   mispred_cnt_d;

    logic [IDX_BITS-1:0] if_idx_s;
    logic [IDX_BITS-1:0] ex_idx_s;
    logic                res_s;
    logic                mispred_s;
    logic [1:0]          ctr_d;
    logic                unused_pc_bits_s;

    // Word-aligned PCs: drop the byte offset, keep IDX_BITS bits, no tag
    assign if_idx_s = if_pc[IDX_BITS+1:2];
    assign ex_idx_s = ex_pc[IDX_BITS+1:2];
    assign unused_pc_bits_s = ^{if_pc[PC_W-1:IDX_BITS+2], if_pc[1:0]};

    // Anything reaching EX while flushing is wrong-path and must not train
    assign res_s     = ex_valid && ex_is_branch && (state_q == IDLE);
    assign mispred_s = res_s && (ex_taken != ex_pred_taken);

    assign pred_taken = if_valid && (state_q == IDLE) && ctr_q[if_idx_s][1];

    bp_sat_ctr2 u_sat_ctr (
        .ctr   (ctr_q[ex_idx_s]),
        .taken (ex_taken),
        .next  (ctr_d)
    );

    // Counter table; the fetch lookup reads the pre-update value this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_CTR;
            end
        end else if (res_s) begin
            ctr_q[ex_idx_s] <= ctr_d;
        end
    end

    // Redirect / flush sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispred_s) begin
                        state_q          <= FLUSH;
                        fcnt_q           <= FCNT_TOP;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= ex_taken ? ex_target : (ex_pc + PC_STEP);
                        flush_q          <= 1'b1;
                    end else begin
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b0;
                    end
                end
                FLUSH: begin
                    redirect_valid_q <= 1'b0;
                    if (fcnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q  <= fcnt_q - FCNT_W'(1);
                        flush_q <= 1'b1;
                    end
                end
                default: begin
                    state_q          <= IDLE;
                    fcnt_q           <= '0;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                end
            endcase
        end
    end

    // Statistics next-state; a clear wins over a same-cycle increment
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (cnt_clr) begin
            branch_cnt_d  = '0;
            mispred_cnt_d = '0;
        end else begin
            if (res_s && (branch_cnt_q != STAT_MAX)) begin
                branch_cnt_d = branch_cnt_q + STAT_W'(1);
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
            if (mispred_s && (mispred_cnt_q != STAT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_o        = flush_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: a per-cycle vector table followed
// by hand-written reset-during-flush and post-reset checks.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_o;
    logic        cnt_clr;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    branch_predict_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_taken       (ex_taken),
        .ex_pred_taken  (ex_pred_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_o        (flush_o),
        .cnt_clr        (cnt_clr),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ifv;
        logic [31:0] ifpc;
        logic        exv;
        logic        exb;
        logic [31:0] expc;
        logic [31:0] extgt;
        logic        ext;
        logic        expr;
        logic        clr;
        logic        e_pred;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
        logic [15:0] e_bc;
        logic [15:0] e_mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ifv, input logic [31:0] ifpc,
                                input logic exv, input logic exb,
                                input logic [31:0] expc, input logic [31:0] extgt,
                                input logic ext, input logic expr, input logic clr,
                                input logic e_pred, input logic e_rv,
                                input logic [31:0] e_rpc, input logic e_fl,
                                input logic [15:0] e_bc, input logic [15:0] e_mc);
        vec_t v;
        v.ifv = ifv;  v.ifpc = ifpc;  v.exv = exv;  v.exb = exb;
        v.expc = expc; v.extgt = extgt; v.ext = ext; v.expr = expr; v.clr = clr;
        v.e_pred = e_pred; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl;
        v.e_bc = e_bc; v.e_mc = e_mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_valid      = 1'b0;
        if_pc         = 32'h0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_pc         = 32'h0;
        ex_target     = 32'h0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // Tests 1-2: reset state, taken mispredict then correct predict at 0x40
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 16'd0, 16'd0));
        vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 16'd0, 16'd0));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 16'd1, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 16'd1, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 16'd1, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 16'd2, 16'd1));
        // Test 3: saturate at ST, then two not-taken steps down to WNT
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'(2 + k), 16'd1));
        end
        vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 16'd6, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 16'd7, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 16'd8, 16'd1));
        // Test 4: not-taken mispredict at 0x100, wrong-path resolves during flush
        vecs.push_back(mk(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 16'd8, 16'd1));
        vecs.push_back(mk(1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 16'd9, 16'd2));
        vecs.push_back(mk(1'b1, 32'h40,  1'b1, 1'b1, 32'h40,  32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 16'd9, 16'd2));
        vecs.push_back(mk(1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 16'd9, 16'd2));
        // Test 5: lookup 0x80 while updating alias 0x180
        vecs.push_back(mk(1'b1, 32'h80,  1'b1, 1'b1, 32'h180, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd9,  16'd2));
        vecs.push_back(mk(1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd10, 16'd2));
        vecs.push_back(mk(1'b1, 32'h180, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd10, 16'd2));
        // if_valid low; ex_is_branch without ex_valid; ex_valid without branch
        vecs.push_back(mk(1'b0, 32'h80,  1'b0, 1'b1, 32'h80,  32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 16'd10, 16'd2));
        vecs.push_back(mk(1'b1, 32'h80,  1'b1, 1'b0, 32'h80,  32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd10, 16'd2));
        vecs.push_back(mk(1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'd10, 16'd2));
        // Test 6b: cnt_clr with a same-cycle mispredicting resolve
        vecs.push_back(mk(1'b1, 32'h80,  1'b1, 1'b1, 32'h80,  32'h400, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 16'd10, 16'd2));
        vecs.push_back(mk(1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 16'd0,  16'd0));
        vecs.push_back(mk(1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 16'd0,  16'd0));
        vecs.push_back(mk(1'b1, 32'h80,  1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 16'd0,  16'd0));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_redirect_pc", redirect_pc, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            if_valid      = vecs[i].ifv;
            if_pc         = vecs[i].ifpc;
            ex_valid      = vecs[i].exv;
            ex_is_branch  = vecs[i].exb;
            ex_pc         = vecs[i].expc;
            ex_target     = vecs[i].extgt;
            ex_taken      = vecs[i].ext;
            ex_pred_taken = vecs[i].expr;
            cnt_clr       = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pred});
            chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].e_fl});
            chk($sformatf("v%0d_branch_cnt", i), {16'd0, branch_cnt}, {16'd0, vecs[i].e_bc});
            chk($sformatf("v%0d_mispred_cnt", i), {16'd0, mispred_cnt}, {16'd0, vecs[i].e_mc});
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            end
        end

        // Test 6a: mispredict at 0x40, then reset in the first flush cycle
        @(negedge clk);
        drive_idle();
        if_valid      = 1'b1;
        if_pc         = 32'h40;
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = 32'h40;
        ex_target     = 32'h500;
        ex_taken      = 1'b1;
        ex_pred_taken = 1'b0;
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre_rst_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("pre_rst_flush", {31'd0, flush_o}, 32'd1);
        chk("pre_rst_redirect_pc", redirect_pc, 32'h500);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", {31'd0, flush_o}, 32'd0);
        chk("mid_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("mid_rst_redirect_pc", redirect_pc, 32'h0);
        chk("mid_rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
        chk("mid_rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
        @(negedge clk);
        #1;
        chk("held_rst_flush", {31'd0, flush_o}, 32'd0);
        chk("held_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        rst_n    = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h40;
        #1;
        chk("post_rst_pred_0x40", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h80;
        #1;
        chk("post_rst_pred_0x80", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("post_rst_flush", {31'd0, flush_o}, 32'd0);
        chk("post_rst_pred_0x80_later", {31'd0, pred_taken}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
